// File: rtl/needs_pkg.sv
// needs_pkg: state encoding, req/ack bit indices and saturating helpers shared by the needs scheduler
package needs_pkg;
  typedef enum logic [2:0] {IDLE, DEC_FOOD, DEC_FUN, DEC_REST, LIFE_UPD, ACTION} state_e;
  localparam int IND_PLAY  = 0;
  localparam int IND_EAT   = 1;
  localparam int IND_SLEEP = 2;
  localparam int IND_HEAL  = 3;
  localparam logic [6:0] MAX_VAL = 7'd100;
  function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, MAX_VAL}) ? MAX_VAL : s[6:0];
  endfunction
  function automatic logic [6:0] sat_dec(input logic [6:0] a);
    return (a != 7'd0) ? a - 7'd1 : a;
  endfunction
endpackage

// File: rtl/needs_tick_div.sv
// needs_tick_div: free-running tick divider plus a tick counter flagging every DECAY_PERIOD-th tick
module needs_tick_div #(
  parameter int TICK_DIV     = 5000000,
  parameter int DECAY_PERIOD = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o,
  output logic decay_tick_o
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  assign tick_o = cnt_q == TW'(TICK_DIV - 1);
  assign decay_tick_o = tick_o && dcnt_q == DW'(DECAY_PERIOD - 1);
  // wrap the cycle counter on every tick and the decay counter on every decay tick
  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    dcnt_d = decay_tick_o ? '0 : tick_o ? dcnt_q + 1'b1 : dcnt_q;
  end
  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dcnt_q <= dcnt_d;
    end
endmodule

// File: rtl/needs_scheduler.sv
// needs_scheduler: serialises decay, life update and player actions onto the four need registers.
// Define NEEDS_DEATH_LATCH_EN to make death sticky and freeze the pet until reset.
module needs_scheduler
  import needs_pkg::*;
#(
  parameter int TICK_DIV     = 5000000,
  parameter int DECAY_PERIOD = 1,
  parameter int ACT_STEP     = 25,
  parameter int LIFE_PLUS    = 70,
  parameter int LIFE_MINUS   = 30,
  parameter int DISEASE_TH   = 20
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       run,
  input  logic [3:0] req,
  output logic [3:0] ack,
  output logic [6:0] food,
  output logic [6:0] fun,
  output logic [6:0] rest,
  output logic [6:0] life,
  output logic       disease,
  output logic       death,
  output logic       busy
);
  state_e state_q, state_d;
  logic pend_q, pend_d, pdec_q, pdec_d;
  logic [1:0] ptr_q, ptr_d, gnt_q, gnt_d, sel;
  logic [3:0] mask_q, mask_d, reqm;
  logic [6:0] food_q, food_d, fun_q, fun_d, rest_q, rest_d, life_q, life_d;
  logic dis_q, dis_d, dth_q, dth_d;
  logic tick, decay_tick, tk, tk_dec, go, grant, act, frz;
  logic [1:0] p, m;
  logic signed [8:0] lsum;

  needs_tick_div #(.TICK_DIV(TICK_DIV), .DECAY_PERIOD(DECAY_PERIOD)) u_div (
    .clk_i(clk),
    .rst_ni(btn_reset),
    .tick_o(tick),
    .decay_tick_o(decay_tick)
  );

`ifdef NEEDS_DEATH_LATCH_EN
  assign frz = dth_q | (life_q == 7'd0);
`else
  assign frz = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk or negedge btn_reset)
    if (!btn_reset) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      pdec_q <= 1'b0;
      ptr_q <= 2'd0;
      gnt_q <= 2'd0;
      mask_q <= 4'd0;
      food_q <= MAX_VAL;
      fun_q <= MAX_VAL;
      rest_q <= MAX_VAL;
      life_q <= MAX_VAL;
      dis_q <= 1'b0;
      dth_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pdec_q <= pdec_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      mask_q <= mask_d;
      food_q <= food_d;
      fun_q <= fun_d;
      rest_q <= rest_d;
      life_q <= life_d;
      dis_q <= dis_d;
      dth_q <= dth_d;
    end

  // next state: a pending tick beats any request; requests are granted round-robin from ptr_q
  always_comb begin
    tk = pend_q | (tick & run);
    tk_dec = pdec_q | (decay_tick & run);
    reqm = req & ~mask_q;
    sel = ptr_q;
    for (int i = 3; i >= 0; i--) if (reqm[ptr_q + 2'(i)]) sel = ptr_q + 2'(i);
    go = state_q == IDLE && !frz;
    grant = go && !tk && |reqm;
    state_d = state_q == DEC_FOOD ? DEC_FUN : state_q == DEC_FUN ? DEC_REST : state_q == DEC_REST ? LIFE_UPD : IDLE;
    if (go && tk) state_d = tk_dec ? DEC_FOOD : LIFE_UPD;
    else if (grant) state_d = ACTION;
    pend_d = tk & ~go;
    pdec_d = tk_dec & ~go;
    gnt_d = grant ? sel : gnt_q;
    ptr_d = grant ? sel + 2'd1 : ptr_q;
  end

  // outputs and the single register write selected by the current state
  always_comb begin
    act = state_q == ACTION;
    ack = act ? 4'b0001 << gnt_q : 4'b0000;
    busy = state_q != IDLE;
    mask_d = ack;
    p = 2'(food_q >= 7'(LIFE_PLUS)) + 2'(fun_q >= 7'(LIFE_PLUS)) + 2'(rest_q >= 7'(LIFE_PLUS));
    m = 2'(food_q <= 7'(LIFE_MINUS)) + 2'(fun_q <= 7'(LIFE_MINUS)) + 2'(rest_q <= 7'(LIFE_MINUS));
    lsum = $signed({2'b00, life_q}) + $signed({7'b0, p}) - $signed({7'b0, m});
    food_d = state_q == DEC_FOOD ? sat_dec(food_q) : act && gnt_q == 2'(IND_EAT) ? sat_add(food_q, 7'(ACT_STEP)) : food_q;
    fun_d = state_q == DEC_FUN ? sat_dec(fun_q) : act && gnt_q == 2'(IND_PLAY) ? sat_add(fun_q, 7'(ACT_STEP)) : fun_q;
    rest_d = state_q == DEC_REST ? sat_dec(rest_q) : act && gnt_q == 2'(IND_SLEEP) ? MAX_VAL : rest_q;
    life_d = state_q == LIFE_UPD ? (lsum < 0 ? 7'd0 : lsum > 9'sd100 ? MAX_VAL : lsum[6:0]) :
             act && gnt_q == 2'(IND_HEAL) && dis_q ? sat_add(life_q, 7'(ACT_STEP)) : life_q;
    dis_d = life_q <= 7'(DISEASE_TH);
`ifdef NEEDS_DEATH_LATCH_EN
    dth_d = dth_q | (life_q == 7'd0);
`else
    dth_d = life_q == 7'd0;
`endif
  end

  assign food = food_q;
  assign fun = fun_q;
  assign rest = rest_q;
  assign life = life_q;
  assign disease = dis_q;
  assign death = dth_q;
endmodule

// File: doc/needs_scheduler.md
# needs_scheduler

Owns the pet's four need registers (food, fun, rest, life) and sequences every update to them. Periodic decay and player actions (play, eat, sleep, heal) are requesters on one shared update datapath, so at most one register is written per cycle. It sits between the top-level game FSM, which raises action requests, and the OLED/LED status paths, which read the need values and the disease/death flags.

## Interface
Parameters:
- TICK_DIV, 5000000: clk cycles per tick (0.1 s at 50 MHz).
- DECAY_PERIOD, 1: ticks between decrements of food/fun/rest.
- ACT_STEP, 25: amount added by play/eat/heal.
- LIFE_PLUS, 70: a need >= this adds 1 to life per tick.
- LIFE_MINUS, 30: a need <= this subtracts 1 from life per tick.
- DISEASE_TH, 20: life <= this raises disease.

Ports:
- clk  in  1  system clock.
- btn_reset  in  1  asynchronous, active-low reset.
- run  in  1  decay enable; 0 pauses decay and life update (START screen).
- req  in  4  action requests, bit0 play, bit1 eat, bit2 sleep, bit3 heal; level, held until acked.
- ack  out  4  one-hot, one-cycle grant matching req bit.
- food, fun, rest, life  out  7 each  need values, 0..100.
- disease  out  1  registered, life <= DISEASE_TH.
- death  out  1  registered, life == 0.
- busy  out  1  high while not in IDLE.

## Operation
- Tick divider: counter 0..TICK_DIV-1; a one-cycle tick pulses at TICK_DIV-1. Tick sets pending_tick only when run=1. pending_tick saturates at 1, so extra ticks coalesce. A second counter counts 0..DECAY_PERIOD-1 and marks the decay ticks.
- States: IDLE, DEC_FOOD, DEC_FUN, DEC_REST, LIFE_UPD, ACTION.
- From IDLE, pending_tick has priority over req:
  - On a decay tick, go IDLE -> DEC_FOOD -> DEC_FUN -> DEC_REST -> LIFE_UPD -> IDLE.
  - On a non-decay tick, go IDLE -> LIFE_UPD -> IDLE.
  - pending_tick clears on entry to the sequence.
- DEC_*: value -= 1 if value > 0, otherwise unchanged.
- LIFE_UPD: m = number of needs <= LIFE_MINUS; p = number of needs >= LIFE_PLUS. life = clamp(life + p - m, 0, 100), computed in a 9-bit signed intermediate. It uses the post-decay values.
- With no pending tick and req != 0, IDLE -> ACTION.
  - Grant is round-robin: search starts at the bit after the last granted bit. Reset pointer = bit0.
- ACTION drives ack for the granted bit and applies the effect:
  - play: fun = min(fun + ACT_STEP, 100).
  - eat: food = min(food + ACT_STEP, 100).
  - sleep: rest = 100.
  - heal: life = min(life + ACT_STEP, 100) if disease = 1; otherwise acked with no effect.
- The bit just acked is masked for the first IDLE cycle after ACTION, so there is no double grant while the requester drops req.
- disease and death are registered every cycle from the current life.

## Timing
- Reset values:
  - food = fun = rest = life = 100.
  - disease = 0, death = 0, ack = 0, busy = 0.
  - state IDLE; counters 0; pending_tick 0; RR pointer at play.
- Tick at cycle T: pending set at T+1. DEC_FOOD at T+1 if IDLE. New food visible at T+2, fun at T+3, rest at T+4, life at T+5. disease/death follow at T+6.
- req sampled in IDLE at cycle N: ACTION at N+1 with ack high. The updated value is visible at N+2. ack is high for exactly one cycle.
- A req arriving during a decay sequence waits; worst-case grant latency is 6 cycles.
- A tick arriving during ACTION is kept pending and serviced on the next IDLE cycle.
- If req drops before ack, no grant is issued. If it drops while in ACTION, the ack is still issued.
- Reset mid-sequence restores all reset values at once; a partial decay is not completed.
- run=0 mid-sequence: the current sequence finishes, and no new ticks become pending.

## Configuration
- NEEDS_DEATH_LATCH_EN
  - Defined: death is sticky once life reaches 0. While dead, decay stops, req is never acked, and all values freeze until btn_reset.
  - Undefined: death = (life == 0) each cycle. Decay and actions continue, so a heal can revive the pet.

## Structure
- Package needs_pkg holds:
  - the state encoding;
  - req/ack bit indices (IND_PLAY, IND_EAT, IND_SLEEP, IND_HEAL);
  - MAX_VAL = 100;
  - the saturating add/subtract functions on 7-bit values.
- Sub-module needs_tick_div: tick divider plus DECAY_PERIOD counter. Outputs are the tick and decay_tick pulses.

## Test plan
- Reset with TICK_DIV=10, run=1, no req: after 1 tick, food/fun/rest = 99 and life = 100 (clamped). After 70 decay steps, food = fun = rest = 30 and life has started decrementing by 3 per tick.
- food = 20, life = 50, heal asserted: ack[3] for 1 cycle, life unchanged (disease=0). Once life <= 20, heal gives life = min(life + 25, 100).
- req = 4'b0011 held across several grants: acks alternate play, eat, play, eat; fun and food each +25, saturating at 100.
- Tick and req in the same cycle: decay sequence runs first (busy for 4 cycles), ack follows at the 6th cycle.
- Drive life to 0: death = 1 next cycle. With NEEDS_DEATH_LATCH_EN, later req gets no ack and values freeze; without it, heal is acked and death returns to 0.
- btn_reset asserted during DEC_FUN: all outputs return to reset values immediately; after release, the next tick starts a full sequence.
